// File: rtl/ram128_fifo_pkg.sv
// ---------------------------------------------------------------------------
// ram128_fifo_pkg: shared sizes for the RAM128-backed FIFO.       Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ram128_fifo_pkg;
  localparam int unsigned FIFO_DEPTH = 128;
  localparam int unsigned ADDR_W     = 7;
  localparam int unsigned CNT_W      = 8;
  localparam int unsigned OBUF_DEPTH = 2;
  localparam int unsigned OBUF_CNT_W = $clog2(OBUF_DEPTH + 1);
endpackage

`default_nettype wire

// File: rtl/ram128_fifo_if.sv
// ---------------------------------------------------------------------------
// ram128_fifo_if: write-side and read-side AXI-Stream bundle.     Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface ram128_fifo_if #(
  parameter int WSIZE = 4
);
  logic               s_tvalid;
  logic [WSIZE*8-1:0] s_tdata;
  logic               s_tready;
  logic               m_tvalid;
  logic [WSIZE*8-1:0] m_tdata;
  logic               m_tready;

  // slave: the FIFO's view; master: the environment driving it
  modport slave  (input  s_tvalid, s_tdata, m_tready,
                  output s_tready, m_tvalid, m_tdata);
  modport master (output s_tvalid, s_tdata, m_tready,
                  input  s_tready, m_tvalid, m_tdata);
endinterface

`default_nettype wire

// File: rtl/ram128_fifo_obuf.sv
// ---------------------------------------------------------------------------
// ram128_fifo_obuf: 2-entry in-order output buffer with AXIS master side.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ram128_fifo_obuf
  import ram128_fifo_pkg::*;
#(
  parameter int DW = 32
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  input  wire logic                  clr,
  input  wire logic                  cap,
  input  wire logic [DW-1:0]         cap_data,
  input  wire logic                  m_tready,
  output logic                       m_tvalid,
  output logic [DW-1:0]              m_tdata,
  output logic [OBUF_CNT_W-1:0]      level,
  output logic                       pop
);

  logic [DW-1:0] second;

  assign pop = m_tvalid && m_tready;

  // m_tdata is itself the head slot, so the output is a plain register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      second   <= '0;
      level    <= '0;
    end else if (clr) begin
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      second   <= '0;
      level    <= '0;
    end else begin
      unique case ({cap, pop})
        2'b10: begin
          if (level == '0) m_tdata <= cap_data;
          else             second  <= cap_data;
          level    <= level + OBUF_CNT_W'(1);
          m_tvalid <= 1'b1;
        end
        2'b01: begin
          m_tdata  <= second;
          level    <= level - OBUF_CNT_W'(1);
          m_tvalid <= (level != OBUF_CNT_W'(1));
        end
        2'b11: begin
          if (level == OBUF_CNT_W'(1)) begin
            m_tdata <= cap_data;
          end else begin
            m_tdata <= second;
            second  <= cap_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/ram128_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// ram128_fifo_ctrl: 128-deep AXIS FIFO on one single-port RAM128. Rev 1.0
// Optional macro FIFO_LEVEL_IRQ_EN adds the thresh input and irq output.
// ---------------------------------------------------------------------------
`default_nettype none

module ram128_fifo_ctrl
  import ram128_fifo_pkg::*;
#(
  parameter int WSIZE = 4
) (
  input  wire logic                  axis_clk,
  input  wire logic                  axis_rst_n,
  input  wire logic                  clr,
  ram128_fifo_if.slave               axis,
  output logic [CNT_W-1:0]           count,
  output logic                       ram_en,
  output logic [WSIZE-1:0]           ram_we,
  output logic [ADDR_W-1:0]          ram_a,
  output logic [WSIZE*8-1:0]         ram_di,
  input  wire logic [WSIZE*8-1:0]    ram_do
`ifdef FIFO_LEVEL_IRQ_EN
  ,
  input  wire logic [CNT_W-1:0]      thresh,
  output logic                       irq
`endif
);

  logic                  run;
  logic [ADDR_W-1:0]     wr_ptr;
  logic [ADDR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]      ram_cnt;
  logic                  rd_inflight;
  logic [OBUF_CNT_W-1:0] obuf_cnt;
  logic                  pop;
  logic [OBUF_CNT_W:0]   obuf_used;
  logic                  do_rd;
  logic                  do_wr;
  logic                  s_ready;
  logic [CNT_W-1:0]      ram_cnt_next;
  logic [CNT_W-1:0]      count_next;

  // obuf_used is also next cycle's obuf occupancy; a read always wins the port
  always_comb begin
    obuf_used    = {1'b0, obuf_cnt} + (OBUF_CNT_W + 1)'(rd_inflight)
                 - (OBUF_CNT_W + 1)'(pop);
    do_rd        = run && !clr && (ram_cnt != '0)
                 && (obuf_used < (OBUF_CNT_W + 1)'(OBUF_DEPTH));
    s_ready      = run && !clr && (ram_cnt < CNT_W'(FIFO_DEPTH)) && !do_rd;
    do_wr        = axis.s_tvalid && s_ready;
    ram_en       = do_rd || do_wr;
    ram_we       = {WSIZE{do_wr}};
    ram_a        = do_rd ? rd_ptr : (do_wr ? wr_ptr : '0);
    ram_di       = do_wr ? axis.s_tdata : '0;
    ram_cnt_next = ram_cnt + CNT_W'(do_wr) - CNT_W'(do_rd);
    count_next   = ram_cnt_next + CNT_W'(obuf_used) + CNT_W'(do_rd);
  end

  assign axis.s_tready = s_ready;

  // run holds s_tready low until the first edge after reset release
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      run         <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      ram_cnt     <= '0;
      rd_inflight <= 1'b0;
      count       <= '0;
    end else begin
      run <= 1'b1;
      if (clr) begin
        wr_ptr      <= '0;
        rd_ptr      <= '0;
        ram_cnt     <= '0;
        rd_inflight <= 1'b0;
        count       <= '0;
      end else begin
        if (do_wr) wr_ptr <= wr_ptr + ADDR_W'(1);
        if (do_rd) rd_ptr <= rd_ptr + ADDR_W'(1);
        ram_cnt     <= ram_cnt_next;
        rd_inflight <= do_rd;
        count       <= count_next;
      end
    end
  end

  ram128_fifo_obuf #(
    .DW (WSIZE * 8)
  ) u_obuf (
    .clk      (axis_clk),
    .rst_n    (axis_rst_n),
    .clr      (clr),
    .cap      (rd_inflight),
    .cap_data (ram_do),
    .m_tready (axis.m_tready),
    .m_tvalid (axis.m_tvalid),
    .m_tdata  (axis.m_tdata),
    .level    (obuf_cnt),
    .pop      (pop)
  );

`ifdef FIFO_LEVEL_IRQ_EN
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) irq <= 1'b0;
    else             irq <= (thresh != '0) && (count >= thresh);
  end
`endif

endmodule

`default_nettype wire
